// File: rtl/branch_flag_unit_pkg.sv
// Shared definitions for the MiniRISC branch/flag unit.
// Holds the branch opcode encoding, the resolver FSM states, the bit
// positions of the architectural flags and the link register index.
// No ports: this is a package imported by the interface and both modules.
package minirisc_branch_pkg;

  typedef enum logic [2:0] {
    B    = 3'd0,
    BR   = 3'd1,
    BLTZ = 3'd2,
    BZ   = 3'd3,
    BNZ  = 3'd4,
    BL   = 3'd5,
    BCY  = 3'd6,
    BNCY = 3'd7
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    SQUASH  = 2'd2
  } state_t;

  localparam int ZERO  = 0;
  localparam int SIGN  = 1;
  localparam int CARRY = 2;

  localparam int LINK_REG = 31;

  // Only BL produces a link write; kept here so every user agrees on it.
  function automatic logic op_links(input br_op_t op);
    return (op == BL);
  endfunction

endpackage

// File: rtl/branch_flag_unit_if.sv
// Branch request channel from the execute stage into the branch/flag unit.
// Signals:
//   valid  - branch request present
//   ready  - unit can accept a branch this cycle
//   op     - branch opcode
//   pc     - PC of the branch instruction
//   offset - sign-extended, byte-scaled offset
//   rs     - register operand
// master drives the request, slave (the unit) returns ready.
interface branch_flag_unit_if #(
  parameter int DATA_W = 32
);
  import minirisc_branch_pkg::*;

  logic              valid;
  logic              ready;
  br_op_t            op;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] rs;

  modport master (
    output valid, op, pc, offset, rs,
    input  ready
  );

  modport slave (
    input  valid, op, pc, offset, rs,
    output ready
  );

endinterface

// File: rtl/branch_flag_unit_cond.sv
// Combinational branch condition and target evaluation.
// Ports:
//   op      - branch opcode
//   rs      - register operand
//   flags_q - architectural flags {carry, sign, zero}
//   pc      - PC of the branch
//   offset  - byte offset added to pc for PC-relative targets
//   taken   - branch condition holds
//   target  - redirect address (pc + offset, or rs for BR)
module branch_cond
  import minirisc_branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  br_op_t            op,
  input  logic [DATA_W-1:0] rs,
  input  logic [2:0]        flags_q,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] offset,
  output logic              taken,
  output logic [DATA_W-1:0] target
);

  // Zero and sign are architectural state but no current opcode tests them;
  // folding them here keeps the port complete for future conditions.
  logic unused_flags;
  assign unused_flags = ^{flags_q[ZERO], flags_q[SIGN]};

  // Every opcode except BR jumps PC-relative; the sum wraps modulo 2^DATA_W.
  // The condition is a pure function of the opcode and its operands.
  always_comb begin
    taken  = 1'b0;
    target = pc + offset;
    case (op)
      B:    taken = 1'b1;
      BR: begin
        taken  = 1'b1;
        target = rs;
      end
      BLTZ: taken = rs[DATA_W-1];
      BZ:   taken = (rs == '0);
      BNZ:  taken = (rs != '0);
      BL:   taken = 1'b1;
      BCY:  taken = flags_q[CARRY];
      BNCY: taken = ~flags_q[CARRY];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// MiniRISC branch/flag unit: consumer of ALU results and flags.
// Holds the architectural flag register and resolves branches against it
// or a register operand, producing a one-cycle PC redirect and link write.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   alu_valid         - ALU outputs valid this cycle
//   flag_we           - instruction updates flags (qualified by alu_valid)
//   alu_zero/sign/carry - ALU flag outputs
//   req               - branch request channel (slave side)
//   redirect          - one-cycle pulse, fetch loads redirect_pc
//   redirect_pc       - branch target
//   link_we           - one-cycle pulse, write link_data to r31
//   link_data         - br_pc + 4 of the last BL
//   flags_q           - {carry, sign, zero}
module branch_flag_unit
  import minirisc_branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  branch_flag_unit_if.slave req,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              link_we,
  output logic [DATA_W-1:0] link_data,
  output logic [2:0]        flags_q
);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  br_op_t            op_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] offset_q;
  logic [DATA_W-1:0] rs_q;
  logic              taken;
  logic [DATA_W-1:0] target;

  // Flag register runs independently of the branch FSM; reset beats a
  // simultaneous flag write.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (alu_valid && flag_we) begin
      flags_q <= {alu_carry, alu_sign, alu_zero};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake: requests are only taken in IDLE, so anything
  // presented in RESOLVE or SQUASH is ignored. A taken branch spends one
  // extra cycle in SQUASH to drop the wrong-path slot.
  always_comb begin
    state_d   = state_q;
    req.ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req.ready = 1'b1;
        if (req.valid) begin
          accept  = 1'b1;
          state_d = RESOLVE;
        end
      end
      RESOLVE: state_d = taken ? SQUASH : IDLE;
      SQUASH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance so the condition is judged on a
  // stable copy while the source moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= B;
      pc_q     <= '0;
      offset_q <= '0;
      rs_q     <= '0;
    end else if (accept) begin
      op_q     <= req.op;
      pc_q     <= req.pc;
      offset_q <= req.offset;
      rs_q     <= req.rs;
    end
  end

  branch_cond #(
    .DATA_W (DATA_W)
  ) u_cond (
    .op      (op_q),
    .rs      (rs_q),
    .flags_q (flags_q),
    .pc      (pc_q),
    .offset  (offset_q),
    .taken   (taken),
    .target  (target)
  );

  // Redirect and link outputs are registered at the end of RESOLVE. The
  // pulses drop every other cycle; the target and link data only move on a
  // taken branch (link data only on BL), so they hold across not-taken ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      link_we     <= 1'b0;
      link_data   <= '0;
    end else begin
      redirect <= 1'b0;
      link_we  <= 1'b0;
      if (state_q == RESOLVE && taken) begin
        redirect    <= 1'b1;
        redirect_pc <= target;
        if (op_links(op_q)) begin
          link_we   <= 1'b1;
          link_data <= pc_q + DATA_W'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model of the unit.
module tb_branch_flag_unit;
  import minirisc_branch_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          aluValid;
  logic          flagWe;
  logic          aluZero;
  logic          aluSign;
  logic          aluCarry;
  logic          redirect;
  logic [W-1:0]  redirectPc;
  logic          linkWe;
  logic [W-1:0]  linkData;
  logic [2:0]    flagsQ;

  branch_flag_unit_if #(.DATA_W(W)) brIf ();

  branch_flag_unit #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (aluValid),
    .flag_we     (flagWe),
    .alu_zero    (aluZero),
    .alu_sign    (aluSign),
    .alu_carry   (aluCarry),
    .req         (brIf),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .link_we     (linkWe),
    .link_data   (linkData),
    .flags_q     (flagsQ)
  );

  // 100 MHz-ish free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: flags, a pending accepted request awaiting its verdict,
  // and how many more cycles the unit stays unavailable after a taken one.
  logic [2:0]   mFlags = 3'b000;
  bit           mPend = 0;
  logic [2:0]   mOp;
  logic [W-1:0] mPc, mOff, mRs;
  int           mBusy = 0;
  logic         mRedirect = 0;
  logic [W-1:0] mRedirectPc = '0;
  logic         mLinkWe = 0;
  logic [W-1:0] mLinkData = '0;

  // Branch rules written straight from the opcode table.
  function automatic void modelResolve(input logic [2:0] op, input logic [W-1:0] rs,
                                       input logic [W-1:0] pc, input logic [W-1:0] off,
                                       input logic [2:0] fl, output bit tk,
                                       output logic [W-1:0] tgt);
    tgt = pc + off;
    tk  = 0;
    case (op)
      3'd0: tk = 1;
      3'd1: begin tk = 1; tgt = rs; end
      3'd2: tk = ($signed(rs) < 0);
      3'd3: tk = (rs == 0);
      3'd4: tk = (rs != 0);
      3'd5: tk = 1;
      3'd6: tk = (fl[2] == 1'b1);
      3'd7: tk = (fl[2] == 1'b0);
      default: tk = 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic modelStep();
    bit           tk;
    logic [W-1:0] tgt;
    if (rst) begin
      mFlags = 3'b000; mPend = 0; mBusy = 0;
      mRedirect = 0; mRedirectPc = '0; mLinkWe = 0; mLinkData = '0;
    end else begin
      mRedirect = 0;
      mLinkWe   = 0;
      if (mPend) begin
        modelResolve(mOp, mRs, mPc, mOff, mFlags, tk, tgt);
        if (tk) begin
          mRedirect   = 1;
          mRedirectPc = tgt;
          if (mOp == 3'd5) begin
            mLinkWe   = 1;
            mLinkData = mPc + 4;
          end
          mBusy = 1;
        end
        mPend = 0;
      end else if (mBusy > 0) begin
        mBusy = mBusy - 1;
      end else if (brIf.valid) begin
        mPend = 1;
        mOp   = brIf.op;
        mPc   = brIf.pc;
        mOff  = brIf.offset;
        mRs   = brIf.rs;
      end
      if (aluValid && flagWe) mFlags = {aluCarry, aluSign, aluZero};
    end
  endtask

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model, once per cycle.
  task automatic checkOutput();
    checkVal("redirect",    W'(redirect),     W'(mRedirect));
    checkVal("redirect_pc", redirectPc,       mRedirectPc);
    checkVal("link_we",     W'(linkWe),       W'(mLinkWe));
    checkVal("link_data",   linkData,         mLinkData);
    checkVal("flags_q",     W'(flagsQ),       W'(mFlags));
    checkVal("br_ready",    W'(brIf.ready),   W'(!mPend && mBusy == 0));
  endtask

  // One clock: update the model from current inputs, take the edge, then
  // sample outputs 1 time unit later.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic setIdle();
    rst = 0; aluValid = 0; flagWe = 0; aluZero = 0; aluSign = 0; aluCarry = 0;
    brIf.valid = 0; brIf.op = B; brIf.pc = '0; brIf.offset = '0; brIf.rs = '0;
  endtask

  task automatic idleCycle();
    setIdle();
    applyStimulus();
  endtask

  task automatic resetCycle();
    setIdle();
    rst = 1;
    applyStimulus();
  endtask

  task automatic aluCycle(input logic we, input logic z, input logic s, input logic c);
    setIdle();
    aluValid = 1; flagWe = we; aluZero = z; aluSign = s; aluCarry = c;
    applyStimulus();
  endtask

  task automatic branchCycle(input logic [2:0] op, input logic [W-1:0] pc,
                             input logic [W-1:0] off, input logic [W-1:0] rs);
    setIdle();
    brIf.valid = 1; brIf.op = br_op_t'(op); brIf.pc = pc; brIf.offset = off; brIf.rs = rs;
    applyStimulus();
  endtask

  initial begin
    setIdle();
    #2;
    resetCycle();
    resetCycle();
    checkVal("reset flags",    W'(flagsQ),     32'h0);
    checkVal("reset ready",    W'(brIf.ready), 32'h1);
    checkVal("reset redirect", W'(redirect),   32'h0);

    // Carry set, then BCY taken; held request during RESOLVE/SQUASH dropped.
    aluCycle(1, 0, 0, 1);
    checkVal("carry written", W'(flagsQ), 32'h4);
    branchCycle(BCY, 32'h100, 32'h20, 32'h0);
    checkVal("resolve not ready", W'(brIf.ready), 32'h0);
    branchCycle(B, 32'h500, 32'h4, 32'h0);
    checkVal("bcy redirect", W'(redirect), 32'h1);
    checkVal("bcy target", redirectPc, 32'h120);
    branchCycle(B, 32'h500, 32'h4, 32'h0);
    checkVal("squash pulse end", W'(redirect), 32'h0);
    idleCycle();
    checkVal("squash dropped", W'(brIf.ready), 32'h1);
    idleCycle();
    checkVal("no late redirect", W'(redirect), 32'h0);

    // Flags held without flag_we; BNCY from clear flags.
    resetCycle();
    aluCycle(0, 0, 0, 1);
    checkVal("flags held", W'(flagsQ), 32'h0);
    branchCycle(BNCY, 32'h40, 32'hFFFF_FFF8, 32'h0);
    idleCycle();
    checkVal("bncy redirect", W'(redirect), 32'h1);
    checkVal("bncy target", redirectPc, 32'h38);
    idleCycle();

    // BL with link, then not-taken BZ.
    branchCycle(BL, 32'h200, 32'h1000, 32'h0);
    idleCycle();
    checkVal("bl target", redirectPc, 32'h1200);
    checkVal("bl link_we", W'(linkWe), 32'h1);
    checkVal("bl link_data", linkData, 32'h204);
    idleCycle();
    checkVal("link pulse end", W'(linkWe), 32'h0);
    branchCycle(BZ, 32'h300, 32'h40, 32'h5);
    idleCycle();
    checkVal("bz redirect", W'(redirect), 32'h0);
    checkVal("bz link_we", W'(linkWe), 32'h0);
    checkVal("bz ready", W'(brIf.ready), 32'h1);
    checkVal("bz target held", redirectPc, 32'h1200);

    // Register sign and register target.
    branchCycle(BLTZ, 32'h300, 32'h10, 32'hFFFF_FFEA);
    idleCycle();
    checkVal("bltz taken", W'(redirect), 32'h1);
    checkVal("bltz target", redirectPc, 32'h310);
    idleCycle();
    branchCycle(BR, 32'h300, 32'h10, 32'h0000_0A00);
    idleCycle();
    checkVal("br target", redirectPc, 32'hA00);
    idleCycle();

    // PC wrap-around.
    branchCycle(B, 32'hFFFF_FFFC, 32'h8, 32'h0);
    idleCycle();
    checkVal("wrap target", redirectPc, 32'h4);
    idleCycle();

    // Reset while a taken B is in RESOLVE.
    aluCycle(1, 1, 1, 1);
    branchCycle(B, 32'h800, 32'h40, 32'h0);
    resetCycle();
    checkVal("rst mid redirect", W'(redirect), 32'h0);
    checkVal("rst mid flags", W'(flagsQ), 32'h0);
    checkVal("rst mid ready", W'(brIf.ready), 32'h1);
    idleCycle();
    checkVal("rst mid no pulse", W'(redirect), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      aluValid   = $urandom_range(0, 1);
      flagWe     = $urandom_range(0, 1);
      aluZero    = $urandom_range(0, 1);
      aluSign    = $urandom_range(0, 1);
      aluCarry   = $urandom_range(0, 1);
      brIf.valid = ($urandom_range(0, 1) == 1);
      brIf.op    = br_op_t'($urandom_range(0, 7));
      brIf.pc    = $urandom;
      brIf.offset = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 255));
      brIf.rs    = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumer side of the ALU result/flag interface in the MiniRISC datapath.
- Holds the architectural flag register (zero, sign, carry), updated from ALU outputs.
- Resolves branch instructions against those flags or a register operand, then issues a one-cycle PC redirect and optional link write.
- Sits between the ALU/execute stage and the fetch PC mux.

Parameters:
- DATA_W, 32, width of ALU result, register operand, PC, offset and link data.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU outputs valid this cycle
- flag_we  in  1  instruction in execute updates flags; effective only when alu_valid=1
- alu_zero  in  1  ALU zero flag
- alu_sign  in  1  ALU sign flag
- alu_carry  in  1  ALU carry flag
- br_valid  in  1  branch request
- br_ready  out  1  unit can accept a branch this cycle
- br_op  in  3  branch opcode (encodings in package)
- br_pc  in  DATA_W  PC of the branch instruction
- br_offset  in  DATA_W  sign-extended, byte-scaled offset
- br_rs  in  DATA_W  register operand
- redirect  out  1  one-cycle pulse; fetch loads redirect_pc
- redirect_pc  out  DATA_W  branch target
- link_we  out  1  one-cycle pulse; write link_data to r31
- link_data  out  DATA_W  br_pc + 4
- flags_q  out  3  {carry, sign, zero} architectural flags

Behaviour:
- Reset values:
  - flags_q = 3'b000
  - redirect = 0, redirect_pc = 0
  - link_we = 0, link_data = 0
  - br_ready = 1
  - state = IDLE
- Flag register:
  - On each clk edge with alu_valid & flag_we, flags_q <= {alu_carry, alu_sign, alu_zero}; otherwise flags_q holds.
  - Flag updates are independent of FSM state.
- FSM states: IDLE, RESOLVE, SQUASH.
- IDLE:
  - br_ready = 1.
  - On br_valid, latch br_op, br_pc, br_offset and br_rs, then go to RESOLVE.
  - No branch request: stay in IDLE.
- RESOLVE:
  - br_ready = 0.
  - Condition is evaluated combinationally from the latched request and the current flags_q. flags_q already includes any flag_we write from the accept cycle.
  - A flag write during RESOLVE does not affect this branch.
  - Outputs redirect, redirect_pc, link_we and link_data are registered and valid in the cycle after RESOLVE.
  - Total latency: accept edge to redirect pulse = 2 edges.
  - If taken, go to SQUASH; otherwise go to IDLE.
- SQUASH:
  - br_ready = 0; one wrong-path slot.
  - Any br_valid here is dropped, with no latch and no effect.
  - Always returns to IDLE.
- Condition and target per op:
  - B: always taken; target = pc + offset
  - BR: always taken; target = rs
  - BLTZ: taken when rs[DATA_W-1] = 1; target = pc + offset
  - BZ: taken when rs == 0
  - BNZ: taken when rs != 0
  - BL: always taken; target = pc + offset; link_we = 1 with link_data = pc + 4
  - BCY: taken when carry = 1
  - BNCY: taken when carry = 0
- Redirect pulse behaviour:
  - Not taken: redirect = 0, link_we = 0; redirect_pc and link_data hold their previous values.
  - redirect and link_we are high for exactly one cycle per taken branch and never high for two consecutive cycles.
- Arithmetic: PC additions are modulo 2^DATA_W; wrap-around is silent.
- Back-to-back requests: a held br_valid while br_ready = 0 is not accepted. The source must hold the request or the pipeline must squash it; SQUASH drops it by design.
- Reset mid-operation: rst in RESOLVE or SQUASH returns to IDLE the next edge. No redirect or link pulse is emitted, and flags_q clears.
- rst and flag_we on the same edge: reset wins.

Decomposition:
- Package minirisc_branch_pkg holds:
  - br_op_t, 3-bit: B=0, BR=1, BLTZ=2, BZ=3, BNZ=4, BL=5, BCY=6, BNCY=7
  - state_t: IDLE, RESOLVE, SQUASH
  - flag bit indices: ZERO=0, SIGN=1, CARRY=2
  - LINK_REG = 31
- Sub-module branch_cond: purely combinational; inputs op, rs, flags_q, pc, offset; outputs taken, target. Instantiated once.

Test Plan:
- Carry-taken branch:
  - Stimulus: ALU writes carry=1 (alu_valid=1, flag_we=1); then BCY with pc=0x100, offset=0x20.
  - Required: flags_q=3'b100; redirect=1 for one cycle with redirect_pc=0x120; next br_valid dropped (SQUASH).
- Flags held without flag_we:
  - Stimulus: flag_we=0 while ALU drives carry=1; then BNCY from reset flags, pc=0x40, offset=-8.
  - Required: flags_q stays 000; taken, redirect_pc=0x38.
- BL then not-taken BZ:
  - Stimulus: BL with pc=0x200, offset=0x1000.
  - Required: redirect_pc=0x1200; link_we=1 and link_data=0x204 in the same cycle.
  - Stimulus: BZ with rs=5.
  - Required: redirect=0, link_we=0; next state is IDLE and br_ready=1 one cycle later.
- Register-sign and register-target branches:
  - Stimulus: BLTZ with rs=0xFFFFFFEA (-22).
  - Required: taken.
  - Stimulus: BR with rs=0x0000_0A00.
  - Required: redirect_pc=0xA00.
- Wrap-around:
  - Stimulus: B with pc=0xFFFFFFFC, offset=8.
  - Required: redirect_pc=0x00000004.
- Reset mid-operation:
  - Stimulus: assert rst in RESOLVE of a taken B.
  - Required: no redirect pulse; flags_q=000, br_ready=1 after the reset edge.
